// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 registered stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

    // Number of output channels and the width of the key that selects one.
    localparam int CH_NUM    = 4;
    localparam int KEY_WIDTH = 2;

    typedef logic [KEY_WIDTH-1:0] key_t;
    typedef logic [CH_NUM-1:0]    ch_vec_t;

    // One-hot decode of a channel key.
    function automatic ch_vec_t key_onehot(input key_t key);
        ch_vec_t vec;
        vec = '0;
        vec[key] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux_1_to_4_reg_reg_slice.sv
// One-entry output register slice for a single channel, plus its transfer counter.
// Latency: a beat loaded at edge N is presented after edge N and may leave at edge N+1.
// Backpressure: the slot holds its beat stable while i_ready=0; a new load on the
// draining edge wins, so the slot sustains one beat per cycle.
module reg_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_val,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_val,
    output logic                  o_valid,
    output logic [CNT_WIDTH-1:0]  o_cnt
);

    // A beat leaves this slot on any edge where it is presented and accepted.
    logic out_fire;

    assign out_fire = o_valid & i_ready;

    // Occupancy: a load always leaves the slot full, even if the old beat drains
    // on the same edge; otherwise a drain empties it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
        end else if (out_fire) begin
            o_valid <= 1'b0;
        end
    end

    // Payload only changes on a load, which keeps it stable while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_val <= '0;
        end else if (i_load) begin
            o_val <= i_val;
        end
    end

    // Completed output transfers, wrapping naturally at the counter width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (out_fire) begin
            o_cnt <= o_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 demux: steers each keyed input beat into one of four register slices.
// Latency: one cycle from input acceptance to the beat appearing on its channel.
// Backpressure: o_ready drops only when the addressed slot is full and its consumer stalls;
// beats to other keys keep flowing. i_ready[i_key] reaches o_ready combinationally.
module demux_1_to_4_reg
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [1:0]                         i_key,
    input  logic [DATA_WIDTH-1:0]              i_val,
    input  logic                               i_valid,
    output logic                               o_ready,
    output logic [3:0][DATA_WIDTH-1:0]         o_val,
    output logic [3:0]                         o_valid,
    input  logic [3:0]                         i_ready,
    output logic [3:0][CNT_WIDTH-1:0]          o_cnt
);

    key_t    key;
    logic    sel_valid;
    logic    sel_ready;
    logic    in_fire;
    ch_vec_t load_vec;

    assign key = key_t'(i_key);

    // Addressed slot can take a beat if it is empty or is draining this cycle.
    // Deliberately independent of i_valid so the producer may use it to decide.
    always_comb begin
        sel_valid = o_valid[key];
        sel_ready = i_ready[key];
        o_ready   = ~sel_valid | sel_ready;
    end

    // At most one slot loads per cycle: the one named by the key, and only on a fire.
    always_comb begin
        in_fire  = i_valid & o_ready;
        load_vec = '0;
        if (in_fire) begin
            load_vec = key_onehot(key);
        end
    end

    // Independent per-channel slices; each drains on its own consumer's ready.
    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
        reg_slice #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_slice (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (load_vec[ch]),
            .i_val   (i_val),
            .i_ready (i_ready[ch]),
            .o_val   (o_val[ch]),
            .o_valid (o_valid[ch]),
            .o_cnt   (o_cnt[ch])
        );
    end

endmodule

// File: tb/tb_demux_1_to_4_reg.sv
// Bench for demux_1_to_4_reg: directed scenarios plus random traffic against a scoreboard.
// Latency: n/a.
// Backpressure: consumer ready is driven randomly or per scenario.
module tb_demux_1_to_4_reg;

    localparam int DW = 32;
    localparam int CW = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             key;
    logic [DW-1:0]          val;
    logic                   vld;
    logic                   o_ready;
    logic [3:0][DW-1:0]     o_val;
    logic [3:0]             o_valid;
    logic [3:0]             rdy;
    logic [3:0][CW-1:0]     o_cnt;

    always #5 clk = ~clk;

    demux_1_to_4_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_key   (key),
        .i_val   (val),
        .i_valid (vld),
        .o_ready (o_ready),
        .o_val   (o_val),
        .o_valid (o_valid),
        .i_ready (rdy),
        .o_cnt   (o_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: every accepted beat not yet delivered, in acceptance order.
    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] d;
    } beat_t;

    beat_t sb[$];
    int    exp_cnt[4];
    logic  last_ready;

    function automatic int pending(input int k);
        int n = 0;
        foreach (sb[i]) if (int'(sb[i].ch) == k) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] head(input int k);
        foreach (sb[i]) if (int'(sb[i].ch) == k) return sb[i].d;
        return '0;
    endfunction

    function automatic void drop(input int k);
        for (int i = 0; i < sb.size(); i++) begin
            if (int'(sb[i].ch) == k) begin
                sb.delete(i);
                return;
            end
        end
    endfunction

    function automatic void model_reset();
        sb.delete();
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            logic exp_v;
            exp_v = (pending(k) != 0);
            chk($sformatf("o_valid[%0d]", k), 64'(o_valid[k]), 64'(exp_v));
            if (exp_v) chk($sformatf("o_val[%0d]", k), 64'(o_val[k]), 64'(head(k)));
            chk($sformatf("o_cnt[%0d]", k), 64'(o_cnt[k]), 64'(exp_cnt[k] % (1 << CW)));
        end
    endtask

    // One clock cycle of traffic: drive, check ready, advance the model, check outputs.
    task automatic step(input logic [1:0] k, input logic [DW-1:0] d, input logic v,
                        input logic [3:0] r);
        logic exp_rdy;
        @(negedge clk);
        key = k; val = d; vld = v; rdy = r;
        #1;
        exp_rdy    = (pending(int'(k)) == 0) || r[k];
        last_ready = o_ready;
        chk("o_ready", 64'(o_ready), 64'(exp_rdy));
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            if (pending(c) != 0 && r[c]) begin
                drop(c);
                exp_cnt[c]++;
            end
        end
        if (v && exp_rdy) sb.push_back('{ch: k, d: d});
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        key = '0; val = '0; vld = 1'b0; rdy = '0;
        model_reset();
        #12;
        chk("rst_o_valid", 64'(o_valid), 64'h0);
        chk("rst_o_ready", 64'(o_ready), 64'h1);
        for (int k = 0; k < 4; k++) begin
            chk("rst_o_cnt", 64'(o_cnt[k]), 64'h0);
            chk("rst_o_val", 64'(o_val[k]), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(2'd0, '0, 1'b0, 4'b0000);
        step(2'd1, '0, 1'b0, 4'b1111);

        // Single beat to key 2 appears next cycle and is counted once drained.
        step(2'd2, 32'hA5A5_0002, 1'b1, 4'b1111);
        chk("k2_o_valid", 64'(o_valid), 64'h4);
        chk("k2_o_val", 64'(o_val[2]), 64'hA5A5_0002);
        step(2'd0, '0, 1'b0, 4'b1111);
        chk("k2_o_cnt", 64'(o_cnt[2]), 64'h1);

        // Backpressure on channel 1 while channel 3 keeps accepting.
        step(2'd1, 32'hB1B1_0001, 1'b1, 4'b1101);
        step(2'd1, 32'hB1B1_0002, 1'b1, 4'b1101);
        chk("bp_o_ready", 64'(last_ready), 64'h0);
        chk("bp_hold_val", 64'(o_val[1]), 64'hB1B1_0001);
        step(2'd3, 32'hC3C3_0003, 1'b1, 4'b0101);
        chk("bp_other_ready", 64'(last_ready), 64'h1);
        step(2'd1, 32'hB1B1_0002, 1'b1, 4'b1101);
        chk("bp_hold_val2", 64'(o_val[1]), 64'hB1B1_0001);
        step(2'd1, 32'hB1B1_0002, 1'b1, 4'b1111);
        chk("bp_release_ready", 64'(last_ready), 64'h1);
        chk("bp_second_val", 64'(o_val[1]), 64'hB1B1_0002);
        step(2'd0, '0, 1'b0, 4'b1111);
        chk("bp_drained", 64'(o_valid), 64'h0);

        // Simultaneous load and drain on slot 3.
        step(2'd3, 32'hD3D3_0001, 1'b1, 4'b0000);
        step(2'd3, 32'hD3D3_0002, 1'b1, 4'b1000);
        chk("ld_dr_valid", 64'(o_valid[3]), 64'h1);
        chk("ld_dr_val", 64'(o_val[3]), 64'hD3D3_0002);
        chk("ld_dr_cnt", 64'(o_cnt[3]), 64'(exp_cnt[3] % (1 << CW)));
        step(2'd0, '0, 1'b0, 4'b1111);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(2'($urandom), 32'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
        end

        // Fill all four slots, then reset asynchronously mid-cycle.
        step(2'd0, '0, 1'b0, 4'b1111);
        for (int k = 0; k < 4; k++) step(2'(k), 32'hE000_0000 + 32'(k), 1'b1, 4'b0000);
        chk("full_before_rst", 64'(o_valid), 64'hF);
        @(negedge clk);
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'h0);
        for (int k = 0; k < 4; k++) chk("async_rst_cnt", 64'(o_cnt[k]), 64'h0);
        rdy = 4'b1111;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk("rst_no_fire_cnt", 64'(o_cnt[k]), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'd0, '0, 1'b0, 4'b1111);

        // Stream 256 beats into channel 0; counter wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            step(2'd0, 32'h1000_0000 + 32'(i), 1'b1, 4'b0001);
            chk("stream_ready", 64'(last_ready), 64'h1);
        end
        step(2'd0, '0, 1'b0, 4'b0001);
        chk("stream_wrap_cnt", 64'(o_cnt[0]), 64'h0);
        chk("stream_empty", 64'(o_valid[0]), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
